// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - shared SEC/SECDED code definition for the 32-bit encoder and decoder
package secded_pkg;

  localparam int DATA_W = 32;
  localparam int PAR_W  = 7;
  localparam int CW_W   = DATA_W + PAR_W;
  localparam int POS_W  = 6;

  typedef logic [POS_W-1:0] pos_t;

  // Codeword position of each data bit: positions 1..38 skipping powers of two.
  localparam pos_t DATA_POS [DATA_W] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } buf_state_e;

  typedef struct packed {
    logic [PAR_W-1:0]  parity;
    logic [DATA_W-1:0] data;
  } codeword_t;

  function automatic logic [PAR_W-1:0] calc_parity(input logic [DATA_W-1:0] data);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int k = 0; k < POS_W; k++) begin
        if (DATA_POS[i][k]) p[k] = p[k] ^ data[i];
      end
    end
    // Overall bit makes the full 39-bit codeword even parity.
    p[PAR_W-1] = (^data) ^ (^p[POS_W-1:0]);
    return p;
  endfunction

endpackage

// File: rtl/secded_encoder_if.sv
// rtl/secded_encoder_if.sv - input/output stream bundle of the SECDED encoder
interface secded_encoder_if #(
  parameter int CNT_W = 16
);
  import secded_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_parity;
  logic [CNT_W-1:0]  word_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_parity, word_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_parity, word_cnt
  );

endinterface

// File: rtl/secded_parity_gen.sv
// rtl/secded_parity_gen.sv - combinational 7-bit SECDED check-bit generator
module secded_parity_gen
  import secded_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [PAR_W-1:0]  parity_o
);

  assign parity_o = calc_parity(data_i);

endmodule

// File: rtl/secded_encoder.sv
// rtl/secded_encoder.sv - SECDED encoder with two-entry elastic buffer and word counter
// Optional macro SECDED_ENC_ERR_INJECT_EN adds one-shot codeword error injection.
module secded_encoder
  import secded_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SECDED_ENC_ERR_INJECT_EN
  input  logic               inj_arm,
  input  logic [CW_W-1:0]    inj_mask,
`endif
  secded_encoder_if.slave    bus
);

  buf_state_e        state_q, state_d;
  codeword_t         out_q, out_d;
  codeword_t         skid_q, skid_d;
  codeword_t         new_cw;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAR_W-1:0]  new_par;
  logic              accept;
  logic              xfer;

  secded_parity_gen u_parity_gen (
    .data_i   (bus.in_data),
    .parity_o (new_par)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign xfer   = (state_q != ST_EMPTY) && bus.out_ready;

`ifdef SECDED_ENC_ERR_INJECT_EN
  logic armed_q, armed_d, inj_now;

  // An arm pulse coinciding with an accept applies to that very word.
  assign inj_now = armed_q || inj_arm;
  assign new_cw  = codeword_t'({new_par, bus.in_data} ^ (inj_now ? inj_mask : '0));
  assign armed_d = accept ? 1'b0 : inj_now;

  always_ff @(posedge clk) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= armed_d;
  end
`else
  assign new_cw = codeword_t'({new_par, bus.in_data});
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = new_cw;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          out_d = new_cw;
        end else if (accept) begin
          skid_d  = new_cw;
          state_d = ST_TWO;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (xfer) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_TWO);
    cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, xfer};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q != ST_EMPTY);
  assign bus.out_data   = out_q.data;
  assign bus.out_parity = out_q.parity;
  assign bus.word_cnt   = cnt_q;

endmodule
